modular_arith_engine: RTL and testbench

//  Parametrised, fully sequential successor of the modular-arithmetic accelerator front end.

---
 rtl/modular_arith_engine.sv | 258 +++++++++++++++++++++++++
 tb/tb_modular_arith_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/modular_arith_engine.sv
// Modular arithmetic engine: add/sub/reduce/R-setup/Montgomery mul/exp.
// Latency: add/sub 3, reduce and R setup 2W+3, mul 2W+4, exp (2W+2)(W+1)+2; errors 2.
// Backpressure: start is accepted only in IDLE (busy=0); requests while busy are dropped.
module modular_arith_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] modulant,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err,
  output logic                  r_valid
);

  localparam int W  = DATA_WIDTH;
  localparam int W1 = DATA_WIDTH + 1;
  localparam int CW = $clog2(2 * DATA_WIDTH + 2);

  localparam logic [CW-1:0] LP_W   = CW'(W);
  localparam logic [CW-1:0] LP_WM1 = CW'(W - 1);
  localparam logic [CW-1:0] LP_2W  = CW'(2 * W);
  localparam logic [CW-1:0] LP_2W1 = CW'(2 * W + 1);
  localparam logic [W-1:0]  LP_ONE = W'(1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOD  = 3'b010;
  localparam logic [2:0] OP_RSET = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_EXP  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_DONE} state_t;

  state_t          r_state;
  logic            r_rst_meta;
  logic            r_rst_sync_n;
  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_m;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_step;
  logic [2*W-1:0]  r_div;
  logic [W-1:0]    r_rem;
  logic [W:0]      r_t;
  logic [W-1:0]    r_mx;
  logic [W-1:0]    r_my;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_xbar;
  logic [W-1:0]    r_ebits;
  logic [W-1:0]    r_rmodm;
  logic [W-1:0]    r_r2;
  logic [W-1:0]    r_mod_st;

  logic [W:0]      w_sum;
  logic [W:0]      w_diff;
  logic [W-1:0]    w_add_res;
  logic [W-1:0]    w_sub_res;
  logic [W:0]      w_rem_sh;
  logic [W-1:0]    w_rem_nxt;
  logic [W-1:0]    w_mm_add;
  logic [W+1:0]    w_mm_sum;
  logic [W:0]      w_mm_next;
  logic [W-1:0]    w_fin;
  logic [W-1:0]    w_keep;
  logic            w_is_mont;
  logic            w_chk_err;

  // Add/sub: W+1-bit raw value, one conditional correction by m.
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  assign w_add_res = (w_sum >= {1'b0, r_m}) ? W'(w_sum - {1'b0, r_m}) : w_sum[W-1:0];
  assign w_sub_res = w_diff[W] ? W'(w_diff + {1'b0, r_m}) : w_diff[W-1:0];

  // Shift-subtract step, shared by reduction (dividend bits) and doubling (zero bits).
  assign w_rem_sh  = {r_rem, r_div[2*W-1]};
  assign w_rem_nxt = (w_rem_sh >= {1'b0, r_m}) ? W'(w_rem_sh - {1'b0, r_m}) : w_rem_sh[W-1:0];

  // Bit-serial Montgomery step: t = (t + x_i*y + q*m) / 2, accumulator stays below 2m.
  assign w_mm_add  = r_mx[0] ? r_my : '0;
  assign w_mm_sum  = {1'b0, r_t} + {2'b00, w_mm_add};
  assign w_mm_next = W1'((w_mm_sum + (w_mm_sum[0] ? {2'b00, r_m} : '0)) >> 1);
  assign w_fin     = (r_t >= {1'b0, r_m}) ? W'(r_t - {1'b0, r_m}) : r_t[W-1:0];
  assign w_keep    = r_ebits[W-1] ? w_fin : r_acc;

  // Montgomery ops need an odd modulus whose constants are currently valid.
  assign w_is_mont = (r_op == OP_MUL) || (r_op == OP_EXP);
  assign w_chk_err = (r_m == '0) || (r_op[2:1] == 2'b11) ||
                     (w_is_mont && (!r_m[0] || !r_valid || (r_m != r_mod_st)));

  // Reset synchroniser: assert immediately, release on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta   <= 1'b0;
      r_rst_sync_n <= 1'b0;
    end else begin
      r_rst_meta   <= 1'b1;
      r_rst_sync_n <= r_rst_meta;
    end
  end

  // Control FSM and all datapath registers.
  always_ff @(posedge clk or negedge r_rst_sync_n) begin
    if (!r_rst_sync_n) begin
      r_state  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      r_valid  <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_step   <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_t      <= '0;
      r_mx     <= '0;
      r_my     <= '0;
      r_acc    <= '0;
      r_xbar   <= '0;
      r_ebits  <= '0;
      r_rmodm  <= '0;
      r_r2     <= '0;
      r_mod_st <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_m     <= modulant;
            busy    <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_cnt   <= '0;
          r_step  <= '0;
          r_t     <= '0;
          r_div   <= (r_op == OP_MOD) ? {r_a, r_b} : '0;
          r_rem   <= ((r_op == OP_RSET) && (r_m != LP_ONE)) ? LP_ONE : '0;
          r_mx    <= r_a;
          r_my    <= (r_op == OP_EXP) ? r_r2 : r_b;
          r_acc   <= r_rmodm;
          r_ebits <= r_b;
          if (w_chk_err) begin
            err     <= 1'b1;
            result  <= '0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_ADD, OP_SUB: begin
              result  <= (r_op == OP_ADD) ? w_add_res : w_sub_res;
              err     <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
            OP_MOD, OP_RSET: begin
              if (r_cnt == LP_2W) begin
                done    <= 1'b1;
                r_state <= S_DONE;
                if (r_op == OP_MOD) begin
                  result <= r_rem;
                  err    <= 1'b0;
                end else begin
                  r_r2     <= r_rem;
                  r_mod_st <= r_m;
                  r_valid  <= r_m[0];
                  err      <= ~r_m[0];
                  result   <= LP_ONE;
                end
              end else begin
                r_rem <= w_rem_nxt;
                r_div <= r_div << 1;
                r_cnt <= r_cnt + 1'b1;
                if ((r_op == OP_RSET) && (r_cnt == LP_WM1)) begin
                  r_rmodm <= w_rem_nxt;
                end
              end
            end
            OP_MUL, OP_EXP: begin
              if (r_cnt != LP_W) begin
                r_t   <= w_mm_next;
                r_mx  <= r_mx >> 1;
                r_cnt <= r_cnt + 1'b1;
              end else begin
                r_t    <= '0;
                r_cnt  <= '0;
                r_step <= r_step + 1'b1;
                if (r_op == OP_MUL) begin
                  if (r_step == '0) begin
                    r_mx <= w_fin;
                    r_my <= r_r2;
                  end else begin
                    result  <= w_fin;
                    err     <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                  end
                end else begin
                  if (r_step == '0) begin
                    r_xbar <= w_fin;
                    r_mx   <= r_acc;
                    r_my   <= r_acc;
                  end else if (r_step == LP_2W1) begin
                    result  <= w_fin;
                    err     <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                  end else if (r_step[0]) begin
                    // Square done; always follow with a multiply (constant time).
                    r_acc <= w_fin;
                    r_mx  <= w_fin;
                    r_my  <= r_xbar;
                  end else begin
                    // Multiply done; keep it only if this exponent bit is set.
                    r_acc   <= w_keep;
                    r_ebits <= r_ebits << 1;
                    r_mx    <= w_keep;
                    r_my    <= (r_step == LP_2W) ? LP_ONE : w_keep;
                  end
                end
              end
            end
            default: begin
              err     <= 1'b1;
              result  <= '0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_arith_engine.sv
// Scoreboard bench for modular_arith_engine (W=8).
// Driver pushes expected responses; monitor pops on every done pulse.
// Stimulus is directed vectors with hand-computed results.
module tb_modular_arith_engine;
  localparam int W       = 8;
  localparam int LAT_MUL = -1;
  localparam int LAT_EXP = -2;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic         start    = 1'b0;
  logic [2:0]   op       = 3'b000;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic [W-1:0] modulant = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;
  logic         r_valid;

  int cyc         = 0;
  int n_chk       = 0;
  int n_pass      = 0;
  int next_id     = 0;
  int exp_lat_ref = 0;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    bit           chk_res;
    bit           err;
    bit           rv;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb_q[$];

  modular_arith_engine #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .modulant (modulant),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err),
    .r_valid  (r_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int id, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s (req %0d): got %0d, required %0d", nm, id, act, req);
  endtask

  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", -1, 1, 0);
      end else begin
        e   = sb_q.pop_front();
        lat = cyc - e.acc + 1;
        if (e.chk_res) check("result", e.id, int'(result), int'(e.res));
        check("err", e.id, int'(err), int'(e.err));
        check("r_valid", e.id, int'(r_valid), int'(e.rv));
        if (e.lat > 0) begin
          check("latency", e.id, lat, e.lat);
        end else if (e.lat == LAT_MUL) begin
          check("mul_latency_bound", e.id, int'(lat <= 2*W+6), 1);
        end else begin
          check("exp_latency_bound", e.id, int'(lat <= (2*W+3)*(2*W+2)), 1);
          if (exp_lat_ref == 0) exp_lat_ref = lat;
          else check("exp_latency_const", e.id, lat, exp_lat_ref);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] i_op, input logic [W-1:0] i_a, input logic [W-1:0] i_b,
                       input logic [W-1:0] i_m, input logic [W-1:0] e_res, input bit e_chk,
                       input bit e_err, input bit e_rv, input int e_lat);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("issue_wait_timeout", next_id, 1, 0);
    op       = i_op;
    a        = i_a;
    b        = i_b;
    modulant = i_m;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e.id      = next_id;
    e.res     = e_res;
    e.chk_res = e_chk;
    e.err     = e_err;
    e.rv      = e_rv;
    e.lat     = e_lat;
    e.acc     = cyc;
    sb_q.push_back(e);
    next_id++;
    @(negedge clk);
    start    = 1'b0;
    op       = 3'b111;
    a        = ~i_a;
    b        = ~i_b;
    modulant = ~i_m;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", -1, sb_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", -1, int'(busy), 0);
    check("rst_done", -1, int'(done), 0);
    check("rst_result", -1, int'(result), 0);
    check("rst_err", -1, int'(err), 0);
    check("rst_r_valid", -1, int'(r_valid), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    //     op      a      b      m      res    chk err rv lat
    issue(3'b000, 8'd7,   8'd9,   8'd13,  8'd3,   1, 0, 0, 3);
    issue(3'b001, 8'd7,   8'd9,   8'd13,  8'd11,  1, 0, 0, 3);
    issue(3'b000, 8'd254, 8'd254, 8'd255, 8'd253, 1, 0, 0, 3);
    issue(3'b001, 8'd0,   8'd254, 8'd255, 8'd1,   1, 0, 0, 3);
    issue(3'b010, 8'h01,  8'h00,  8'd13,  8'd9,   1, 0, 0, 19);
    issue(3'b010, 8'h01,  8'h00,  8'd0,   8'd0,   1, 1, 0, 2);
    issue(3'b010, 8'hFF,  8'hFF,  8'd13,  8'd2,   1, 0, 0, 19);
    issue(3'b100, 8'd7,   8'd9,   8'd13,  8'd0,   1, 1, 0, 2);
    issue(3'b011, 8'd0,   8'd0,   8'd13,  8'd1,   1, 0, 1, 19);
    issue(3'b100, 8'd7,   8'd9,   8'd13,  8'd11,  1, 0, 1, LAT_MUL);
    issue(3'b100, 8'd12,  8'd12,  8'd13,  8'd1,   1, 0, 1, LAT_MUL);
    issue(3'b101, 8'd7,   8'd9,   8'd13,  8'd8,   1, 0, 1, LAT_EXP);
    issue(3'b101, 8'd7,   8'd0,   8'd13,  8'd1,   1, 0, 1, LAT_EXP);
    issue(3'b101, 8'd0,   8'd5,   8'd13,  8'd0,   1, 0, 1, LAT_EXP);
    issue(3'b101, 8'd2,   8'd12,  8'd13,  8'd1,   1, 0, 1, LAT_EXP);
    issue(3'b100, 8'd3,   8'd4,   8'd11,  8'd0,   1, 1, 1, 2);
    issue(3'b011, 8'd0,   8'd0,   8'd12,  8'd0,   0, 1, 0, 19);
    issue(3'b110, 8'd1,   8'd1,   8'd13,  8'd0,   1, 1, 0, 2);
    issue(3'b100, 8'd7,   8'd9,   8'd13,  8'd0,   1, 1, 0, 2);
    issue(3'b011, 8'd0,   8'd0,   8'd13,  8'd1,   1, 0, 1, 19);
    issue(3'b100, 8'd7,   8'd9,   8'd13,  8'd11,  1, 0, 1, LAT_MUL);
    drain();

    // Reset in the middle of an exponentiation: outputs clear, no done pulse.
    issue(3'b101, 8'd7, 8'd9, 8'd13, 8'd8, 1, 0, 1, LAT_EXP);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", -1, int'(busy), 0);
    check("midrst_done", -1, int'(done), 0);
    check("midrst_result", -1, int'(result), 0);
    check("midrst_err", -1, int'(err), 0);
    check("midrst_r_valid", -1, int'(r_valid), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Start pulses while busy must be dropped; the next start after done is taken.
    issue(3'b000, 8'd7, 8'd9, 8'd13, 8'd3, 1, 0, 0, 3);
    t = 0;
    while (busy && t < 100) begin
      start    = 1'b1;
      op       = 3'b001;
      a        = 8'd1;
      b        = 8'd1;
      modulant = 8'd13;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    issue(3'b001, 8'd7, 8'd9, 8'd13, 8'd11, 1, 0, 0, 3);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
